can_reg_sequencer: RTL
======================

# can_reg_sequencer

Autonomous register-write sequencer for the Canakari CAN controller node. It accepts one high-level command per handshake: init, transmit, trim or bus-reset. It then issues the full ordered series of 16-bit register writes to the controller, each with an acknowledge handshake and a timeout. It sits between the MOPS-Hub command logic and the Canakari register port, and replaces per-address value generation with parametrised, DLC-aware sequencing.

## Interface
Parameters:
- `PRESCALER`, 16'h00FF: value written to prescaler register 0x0F.
- `BIT_TIMING`, 16'h00A3: value written to bit-timing register 0x0E during init (sjw/tseg1/tseg2).
- `ACC_MASK`, 29'h0: acceptance mask; bits [28:13] go to 0x11, {bits [12:0], 3'b0} go to 0x10.
- `ACC_ID`, 29'h0: acceptance ID; bits [28:13] go to 0x05, {bits [12:0], 3'b0} go to 0x04.
- `IRQ_EN`, 16'h8070: interrupt/enable register 0x12 value.
- `GEN_REG`, 16'h009C: general register 0x0E value for transmit, trim and bus-reset.
- `TRA_CTRL`, 16'h8008: transmission-control register 0x0D value; writing it starts transmission.
- `ACK_TIMEOUT`, 64: maximum number of cycles a write waits for its ack; must be ≥1.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `cmd_valid`, in, 1: command request.
- `cmd_ready`, out, 1: high only in IDLE.
- `cmd_op`, in, 2: 0 INIT, 1 TX, 2 TRIM, 3 BUS_RESET.
- `tx_id`, in, 11: standard identifier for TX.
- `tx_dlc`, in, 4: payload byte count for TX; values >8 are clamped to 8.
- `tx_data`, in, 64: payload; byte1 = [63:56] … byte8 = [7:0].
- `reg_addr`, out, 5: Canakari register address.
- `reg_wdata`, out, 16: write data.
- `reg_wr`, out, 1: write request, held until acked.
- `reg_wr_ack`, in, 1: controller accepts the current write.
- `busy`, out, 1: a sequence is in progress.
- `done`, out, 1: one-cycle pulse when a sequence completes.
- `err`, out, 1: one-cycle pulse when a sequence aborts on timeout.

## Operation
- The command is accepted when `cmd_valid && cmd_ready`. `cmd_op`, `tx_id`, clamped `tx_dlc` and `tx_data` are latched at acceptance; later input changes have no effect.
- Write sequences (address:data, in issue order):
  - INIT: 0x0F:PRESCALER, 0x0E:BIT_TIMING, 0x05, 0x04, 0x11, 0x10, then 0x12:IRQ_EN last. 7 writes.
  - TX:
    - First 0x0C:{tx_id, 5'b0}.
    - Then data registers 0x0A {b1,b2}, 0x09 {b3,b4}, 0x08 {b5,b6}, 0x07 {b7,b8}. Only ceil(dlc/2) of them are written, in that order. An odd final byte is padded with 8'h00 in the low half.
    - Then 0x0E:GEN_REG, then 0x0D:TRA_CTRL last.
    - dlc=0 gives 3 writes; dlc=8 gives 7 writes.
  - TRIM: same as TX with id 11'h555, dlc 8, data 64'hAAAA_AAAA_AAAA_AAAA.
  - BUS_RESET: 0x0E:GEN_REG, then 0x12:IRQ_EN.
- State machine:
  - IDLE → WRITE on acceptance.
  - WRITE: `reg_wr` high with stable `reg_addr`/`reg_wdata`. On ack, go to GAP. On timeout, go to ABORT.
  - GAP: `reg_wr` low for one cycle. Go to WRITE if writes remain, else DONE.
  - DONE: pulse `done`, go to IDLE.
  - ABORT: pulse `err`, go to IDLE. The remaining writes are dropped.
- `reg_wr_ack` outside WRITE is ignored. `cmd_valid` while busy is ignored and not queued.

## Timing
- Reset values: `reg_addr`=0, `reg_wdata`=0, `reg_wr`=0, `busy`=0, `done`=0, `err`=0, `cmd_ready`=1 (the cycle after reset).
- Reset mid-sequence: everything returns to reset values on the next edge, and no further writes are issued.
- Write k (1-based) asserts in cycle 2k−1 after acceptance cycle 0, assuming the ack arrives in the same cycle as the request.
- `done` asserts the cycle after the last GAP:
  - 7 writes: `done` at cycle 14.
  - BUS_RESET: `done` at cycle 4.
- Each extra ack wait cycle delays everything after it by one cycle.
- Timeout counter: cleared on WRITE entry, incremented each un-acked WRITE cycle. If it reaches ACK_TIMEOUT, the next cycle is ABORT. An ack in the same cycle as the timeout wins.
- `busy` is high from the cycle after acceptance through the DONE/ABORT cycle. `cmd_ready` = !busy.

## Structure
- Package `can_seq_pkg` holds:
  - op encodings;
  - register address constants (0x04–0x12);
  - trim ID/data pattern;
  - state enum.
- Sub-module `can_seq_rom`: combinational (op, step index, latched fields) → {addr, data, last}. The FSM, step counter and timeout counter stay in the top level.

## Test plan
- INIT with ack tied high → 7 writes in the order 0x0F:00FF, 0x0E:00A3, 0x05:0000, 0x04:0000, 0x11:0000, 0x10:0000, 0x12:8070; `done` at cycle 14.
- TX id 11'h123, dlc 3, data 64'h1122_3344_xxxx → writes 0x0C:2460, 0x0A:1122, 0x09:3300, 0x0E:009C, 0x0D:8008; `done` at cycle 10.
- TX with dlc 15 → behaves as dlc 8 (7 writes, 0x07 written last before 0x0E and 0x0D).
- BUS_RESET with ack delayed 3 cycles per write → `reg_wr` held stable throughout each wait, 2 writes, `done` at cycle 10.
- ACK_TIMEOUT=4, ack never asserted → `reg_wr` high for 4 cycles, `err` pulse, no `done`, `cmd_ready` high again.
- `rst` asserted during the third TRIM write → all outputs zero next cycle; a new INIT afterwards runs cleanly from its first write.

Source files
------------

// File: rtl/can_seq_pkg.sv
// can_seq_pkg
// Shared definitions for the Canakari register-write sequencer:
//   - command op encodings
//   - Canakari register addresses used by the sequences
//   - fixed trim frame (identifier, length, payload)
//   - sequencer state enum
package can_seq_pkg;

  typedef enum logic [1:0] {
    OP_INIT      = 2'd0,
    OP_TX        = 2'd1,
    OP_TRIM      = 2'd2,
    OP_BUS_RESET = 2'd3
  } op_t;

  localparam logic [4:0] ADDR_ACC_ID_LO   = 5'h04;
  localparam logic [4:0] ADDR_ACC_ID_HI   = 5'h05;
  localparam logic [4:0] ADDR_DATA_78     = 5'h07;
  localparam logic [4:0] ADDR_DATA_56     = 5'h08;
  localparam logic [4:0] ADDR_DATA_34     = 5'h09;
  localparam logic [4:0] ADDR_DATA_12     = 5'h0A;
  localparam logic [4:0] ADDR_TX_ID       = 5'h0C;
  localparam logic [4:0] ADDR_TRA_CTRL    = 5'h0D;
  localparam logic [4:0] ADDR_GEN         = 5'h0E;
  localparam logic [4:0] ADDR_PRESCALER   = 5'h0F;
  localparam logic [4:0] ADDR_ACC_MASK_LO = 5'h10;
  localparam logic [4:0] ADDR_ACC_MASK_HI = 5'h11;
  localparam logic [4:0] ADDR_IRQ_EN      = 5'h12;

  localparam logic [10:0] TRIM_ID   = 11'h555;
  localparam logic [3:0]  TRIM_DLC  = 4'd8;
  localparam logic [63:0] TRIM_DATA = 64'hAAAA_AAAA_AAAA_AAAA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_GAP,
    ST_DONE,
    ST_ABORT
  } state_t;

endpackage

// File: rtl/can_seq_rom.sv
// can_seq_rom
// Combinational sequence table: maps (op, step index, latched frame fields)
// to the register write for that step and flags the final write.
// Ports:
//   op      in  op_t : latched command (TRIM arrives already as TX fields)
//   step    in  3    : 0-based write index within the sequence
//   tx_id   in  11   : latched standard identifier
//   tx_dlc  in  4    : latched payload length, already clamped to 0..8
//   tx_data in  64   : latched payload, byte1 in [63:56]
//   addr    out 5    : register address for this step
//   data    out 16   : register write data for this step
//   last    out 1    : this step is the final write of the sequence
module can_seq_rom
  import can_seq_pkg::*;
#(
  parameter logic [15:0] PRESCALER  = 16'h00FF,
  parameter logic [15:0] BIT_TIMING = 16'h00A3,
  parameter logic [28:0] ACC_MASK   = 29'h0,
  parameter logic [28:0] ACC_ID     = 29'h0,
  parameter logic [15:0] IRQ_EN     = 16'h8070,
  parameter logic [15:0] GEN_REG    = 16'h009C,
  parameter logic [15:0] TRA_CTRL   = 16'h8008
) (
  input  op_t         op,
  input  logic [2:0]  step,
  input  logic [10:0] tx_id,
  input  logic [3:0]  tx_dlc,
  input  logic [63:0] tx_data,
  output logic [4:0]  addr,
  output logic [15:0] data,
  output logic        last
);

  logic [2:0]  n_data;  // number of data-register writes, ceil(dlc/2)
  logic [1:0]  di;      // data-register index for steps 1..n_data
  logic [15:0] word;

  always_comb begin
    addr   = '0;
    data   = '0;
    last   = 1'b0;
    n_data = 3'((tx_dlc + 4'd1) >> 1);
    di     = 2'(step - 3'd1);
    // di=0 selects bytes 1/2 at [63:48], di=3 selects bytes 7/8 at [15:0]
    word   = tx_data[{~di, 4'b0000} +: 16];
    // odd length: the last data word carries one real byte, low half padded
    if (tx_dlc[0] && (step == n_data)) word[7:0] = 8'h00;

    case (op)
      OP_INIT: begin
        case (step)
          3'd0: begin addr = ADDR_PRESCALER;   data = PRESCALER;                end
          3'd1: begin addr = ADDR_GEN;         data = BIT_TIMING;               end
          3'd2: begin addr = ADDR_ACC_ID_HI;   data = ACC_ID[28:13];            end
          3'd3: begin addr = ADDR_ACC_ID_LO;   data = {ACC_ID[12:0], 3'b000};   end
          3'd4: begin addr = ADDR_ACC_MASK_HI; data = ACC_MASK[28:13];          end
          3'd5: begin addr = ADDR_ACC_MASK_LO; data = {ACC_MASK[12:0], 3'b000}; end
          default: begin addr = ADDR_IRQ_EN; data = IRQ_EN; last = 1'b1; end
        endcase
      end
      OP_BUS_RESET: begin
        if (step == 3'd0) begin
          addr = ADDR_GEN;
          data = GEN_REG;
        end else begin
          addr = ADDR_IRQ_EN;
          data = IRQ_EN;
          last = 1'b1;
        end
      end
      default: begin  // TX and TRIM share the frame layout
        if (step == 3'd0) begin
          addr = ADDR_TX_ID;
          data = {tx_id, 5'b00000};
        end else if (step <= n_data) begin
          addr = ADDR_DATA_12 - {3'b000, di};
          data = word;
        end else if (step == 3'(n_data + 3'd1)) begin
          addr = ADDR_GEN;
          data = GEN_REG;
        end else begin
          addr = ADDR_TRA_CTRL;
          data = TRA_CTRL;
          last = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/can_reg_sequencer.sv
// can_reg_sequencer
// Accepts one command (init, transmit, trim, bus-reset) and issues its full
// ordered series of 16-bit Canakari register writes, each held until acked
// or aborted on timeout.
// Ports:
//   clk, rst (sync, active high)
//   cmd_valid/cmd_ready, cmd_op, tx_id, tx_dlc, tx_data : command handshake
//   reg_addr, reg_wdata, reg_wr, reg_wr_ack             : register port
//   busy, done (pulse), err (pulse on timeout)          : status
module can_reg_sequencer
  import can_seq_pkg::*;
#(
  parameter logic [15:0] PRESCALER   = 16'h00FF,
  parameter logic [15:0] BIT_TIMING  = 16'h00A3,
  parameter logic [28:0] ACC_MASK    = 29'h0,
  parameter logic [28:0] ACC_ID      = 29'h0,
  parameter logic [15:0] IRQ_EN      = 16'h8070,
  parameter logic [15:0] GEN_REG     = 16'h009C,
  parameter logic [15:0] TRA_CTRL    = 16'h8008,
  parameter int          ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [10:0] tx_id,
  input  logic [3:0]  tx_dlc,
  input  logic [63:0] tx_data,
  output logic [4:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_wr,
  input  logic        reg_wr_ack,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t      state_reg, state_next;
  logic [2:0]  step_reg, step_next;
  logic [15:0] tcnt_reg, tcnt_next;  // supports ACK_TIMEOUT up to 65536

  op_t         op_reg;
  logic [10:0] id_reg;
  logic [3:0]  dlc_reg;
  logic [63:0] data_reg;

  logic [4:0]  rom_addr;
  logic [15:0] rom_data;
  logic        rom_last;

  can_seq_rom #(
    .PRESCALER (PRESCALER),
    .BIT_TIMING(BIT_TIMING),
    .ACC_MASK  (ACC_MASK),
    .ACC_ID    (ACC_ID),
    .IRQ_EN    (IRQ_EN),
    .GEN_REG   (GEN_REG),
    .TRA_CTRL  (TRA_CTRL)
  ) u_rom (
    .op     (op_reg),
    .step   (step_reg),
    .tx_id  (id_reg),
    .tx_dlc (dlc_reg),
    .tx_data(data_reg),
    .addr   (rom_addr),
    .data   (rom_data),
    .last   (rom_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      step_reg  <= '0;
      tcnt_reg  <= '0;
      op_reg    <= OP_INIT;
      id_reg    <= '0;
      dlc_reg   <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      tcnt_reg  <= tcnt_next;
      if (state_reg == ST_IDLE && cmd_valid) begin
        // TRIM is a TX with a fixed frame, so substitute it here once
        op_reg   <= op_t'(cmd_op);
        id_reg   <= (op_t'(cmd_op) == OP_TRIM) ? TRIM_ID : tx_id;
        dlc_reg  <= (op_t'(cmd_op) == OP_TRIM) ? TRIM_DLC
                  : ((tx_dlc > 4'd8) ? 4'd8 : tx_dlc);
        data_reg <= (op_t'(cmd_op) == OP_TRIM) ? TRIM_DATA : tx_data;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    tcnt_next  = tcnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_next = ST_WRITE;
          step_next  = '0;
          tcnt_next  = '0;
        end
      end
      ST_WRITE: begin
        // an ack in the timeout cycle still completes the write
        if (reg_wr_ack) begin
          step_next  = step_reg + 3'd1;
          tcnt_next  = '0;
          // after the final write the DONE cycle itself serves as the gap
          state_next = rom_last ? ST_DONE : ST_GAP;
        end else if (tcnt_reg == 16'(ACK_TIMEOUT - 1)) begin
          state_next = ST_ABORT;
        end else begin
          tcnt_next = tcnt_reg + 16'd1;
        end
      end
      ST_GAP:   state_next = ST_WRITE;
      ST_DONE:  state_next = ST_IDLE;
      ST_ABORT: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // register port is driven only during WRITE so it reads as zero otherwise
  assign reg_wr    = (state_reg == ST_WRITE);
  assign reg_addr  = reg_wr ? rom_addr : '0;
  assign reg_wdata = reg_wr ? rom_data : '0;
  assign busy      = (state_reg != ST_IDLE);
  assign cmd_ready = !busy;
  assign done      = (state_reg == ST_DONE);
  assign err       = (state_reg == ST_ABORT);

endmodule
